// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks which architectural registers have a write
// still in flight, stalls issue on RAW/WAW hazards, and arbitrates the ALU
// and MEM writeback ports onto a single registered register-file write port.
module reg_scoreboard #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 5,
  parameter int REGISTER_SIZE = 2**ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,

  // Issue side
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [ADDRESS_WIDTH-1:0] issue_rs1,
  input  logic [ADDRESS_WIDTH-1:0] issue_rs2,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  input  logic                     issue_we,

  // Writeback requesters
  input  logic                     alu_wb_valid,
  output logic                     alu_wb_ready,
  input  logic [ADDRESS_WIDTH-1:0] alu_wb_addr,
  input  logic [DATA_WIDTH-1:0]    alu_wb_data,
  input  logic                     mem_wb_valid,
  output logic                     mem_wb_ready,
  input  logic [ADDRESS_WIDTH-1:0] mem_wb_addr,
  input  logic [DATA_WIDTH-1:0]    mem_wb_data,

  // Register-file write port
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0]    wd,

  // Status
  output logic [ADDRESS_WIDTH:0]   busy_count
);

  // The busy vector spans the full index space so any index can be looked up
  // directly; indices at or above REGISTER_SIZE are simply never marked busy.
  localparam int BUSY_DEPTH = 2**ADDRESS_WIDTH;

  // Identity of the most recent writeback winner (round-robin pointer).
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  logic [BUSY_DEPTH-1:0]    busy_q;
  logic [BUSY_DEPTH-1:0]    busy_d;
  logic [ADDRESS_WIDTH:0]   busy_count_d;
  logic                     last_grant_q;
  logic                     last_grant_d;

  logic                     src_hazard;
  logic                     dst_hazard;
  logic                     issue_fire;
  logic                     issue_sets_busy;

  logic                     wb_grant;
  logic [ADDRESS_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]    wb_data;

  // An index is tracked when it is not the hardwired zero register and lies
  // inside the configured register count.
  function automatic logic is_tracked(input logic [ADDRESS_WIDTH-1:0] idx);
    return (idx != '0) && (int'(idx) < REGISTER_SIZE);
  endfunction

  // Issue hazard check against registered busy state only; a writeback granted
  // this same cycle does not unblock an issue until the following cycle.
  always_comb begin
    src_hazard  = busy_q[issue_rs1] | busy_q[issue_rs2];
    dst_hazard  = issue_we & busy_q[issue_rd];
    issue_ready = ~reset & ~src_hazard & ~dst_hazard;
  end

  // Accepted issue that claims a destination register.
  always_comb begin
    issue_fire      = issue_valid & issue_ready;
    issue_sets_busy = issue_fire & issue_we & is_tracked(issue_rd);
  end

  // Round-robin writeback arbiter: a lone requester always wins; under
  // contention the requester that did not win last time is granted.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise an unassigned path infers a latch.
    alu_wb_ready = 1'b0;
    mem_wb_ready = 1'b0;
    if (!reset) begin
      if (alu_wb_valid && mem_wb_valid) begin
        if (last_grant_q == GRANT_MEM) alu_wb_ready = 1'b1;
        else                           mem_wb_ready = 1'b1;
      end else begin
        alu_wb_ready = alu_wb_valid;
        mem_wb_ready = mem_wb_valid;
      end
    end
  end

  // Select the winning writeback onto the shared write path and advance the
  // round-robin pointer on every grant, contended or not.
  always_comb begin
    wb_grant     = alu_wb_ready | mem_wb_ready;
    wb_addr      = mem_wb_ready ? mem_wb_addr : alu_wb_addr;
    wb_data      = mem_wb_ready ? mem_wb_data : alu_wb_data;
    last_grant_d = last_grant_q;
    if (alu_wb_ready)      last_grant_d = GRANT_ALU;
    else if (mem_wb_ready) last_grant_d = GRANT_MEM;
  end

  // Next busy vector: the granted writeback clears its index, an accepted
  // issue sets its destination. The two never target the same index because
  // issue stalls on a busy destination, so their order here is immaterial.
  always_comb begin
    busy_d = busy_q;
    if (wb_grant)        busy_d[wb_addr]  = 1'b0;
    if (issue_sets_busy) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector, registered alongside it so the
  // published count always matches the busy state after each edge.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < BUSY_DEPTH; i++) begin
      busy_count_d = busy_count_d + {{ADDRESS_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  // State and write-port registers. Reset drops all pending busy state and
  // any granted write that has not yet reached the register file.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the busy vector is a small flop array, not a RAM, so resetting
      // it is cheap and required to drop in-flight hazards.
      busy_q       <= '0;
      busy_count   <= '0;
      last_grant_q <= GRANT_MEM;
      RegWrite     <= 1'b0;
      wa           <= '0;
      wd           <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count   <= busy_count_d;
      last_grant_q <= last_grant_d;
      // Index 0 is the hardwired zero register: the grant is consumed but no
      // write is presented to the register file.
      RegWrite     <= wb_grant && (wb_addr != '0);
      if (wb_grant) begin
        wa <= wb_addr;
        wd <= wb_data;
      end
    end
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning register data width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 5, meaning register index width.
REQ-003 The block SHALL have parameter REGISTER_SIZE, default 2**ADDRESS_WIDTH, meaning number of tracked registers.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; all state changes on posedge clk.
REQ-005 clk  input  1  clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 issue_valid  input  1  decode offers an instruction.
REQ-008 issue_ready  output  1  instruction accepted this cycle (issue_valid && issue_ready).
REQ-009 issue_rs1, issue_rs2, issue_rd  input  ADDRESS_WIDTH each  source and destination indices.
REQ-010 issue_we  input  1  instruction writes issue_rd.
REQ-011 alu_wb_valid, mem_wb_valid  input  1 each  writeback request.
REQ-012 alu_wb_ready, mem_wb_ready  output  1 each  writeback granted this cycle.
REQ-013 alu_wb_addr, mem_wb_addr  input  ADDRESS_WIDTH each  writeback index.
REQ-014 alu_wb_data, mem_wb_data  input  DATA_WIDTH each  writeback data.
REQ-015 RegWrite  output  1  registered write enable to register file.
REQ-016 wa  output  ADDRESS_WIDTH  registered write address.
REQ-017 wd  output  DATA_WIDTH  registered write data.
REQ-018 busy_count  output  ADDRESS_WIDTH+1  number of registers with busy bit set.

Function
REQ-019 The block SHALL hold one registered busy bit per register index; index 0 SHALL never be busy.
REQ-020 issue_ready SHALL be 1 only when reset is low and busy[issue_rs1], busy[issue_rs2] are 0 and (issue_we==0 or busy[issue_rd]==0), using the registered busy state (no same-cycle bypass from writeback).
REQ-021 issue_ready SHALL be combinational from registered busy and issue_* inputs, independent of issue_valid.
REQ-022 On accepted issue with issue_we=1 and issue_rd!=0, busy[issue_rd] SHALL be set at that posedge.
REQ-023 Writeback arbitration: one grant per cycle; only one valid -> grant it; both valid -> grant the requester not granted last (round-robin); none -> no grant.
REQ-024 alu_wb_ready/mem_wb_ready SHALL be combinational grant signals, at most one high, never high without its valid; never high while reset is high.
REQ-025 last_grant SHALL update on every grant, including uncontended ones.
REQ-026 On a grant, at that posedge: RegWrite<=1 unless granted addr==0 (then RegWrite<=0), wa<=addr, wd<=data, busy[addr]<=0; with no grant RegWrite<=0, wa/wd hold.
REQ-027 Write latency: grant in cycle N -> RegWrite high in cycle N+1 only; register file commits on negedge of N+1.
REQ-028 Writeback to a non-busy index SHALL still be written; busy unchanged.
REQ-029 Set and clear of the same index in one cycle cannot occur (REQ-020 stalls issue to busy rd); clear on other indices and set SHALL both take effect.
REQ-030 busy_count SHALL be registered and equal the population count of busy after each posedge; range 0..REGISTER_SIZE-1.

Reset
REQ-031 While reset is high at posedge: all busy bits<=0, busy_count<=0, RegWrite<=0, wa<=0, wd<=0, last_grant<=MEM (ALU wins first contention).
REQ-032 Reset mid-operation SHALL discard pending busy state and any granted write not yet driven; no RegWrite in the cycle after reset.

Verification
REQ-033 Issue rd=5 we=1, then issue rs1=5 next cycle -> second issue_ready=0 until the cycle after ALU wb addr=5 is granted; busy_count 1 -> 0.
REQ-034 ALU and MEM valid same cycle (addr 3 and 4) after reset -> ALU granted first, MEM next cycle; RegWrite high two consecutive cycles, wa=3 then 4.
REQ-035 Issue rd=0 we=1 -> busy_count stays 0; wb addr=0 granted -> RegWrite stays 0, wa=0.
REQ-036 Issue rd=7 we=1, then issue rd=7 again -> second stalled (WAW) until wb addr=7 granted.
REQ-037 Busy on regs 2,9; MEM wb addr=2 granted while issue rd=11 accepted same cycle -> busy={9,11}, busy_count=2.
REQ-038 Reset asserted with busy_count=3 and ALU grant same cycle -> next cycle busy_count=0, RegWrite=0, issue_ready=1 for any sources.
